// File: rtl/if_stage_pkg.sv
// Shared constants, FSM encoding and IF/ID payload type for the MIPS fetch stage.
package if_stage_pkg;

    localparam logic [31:0] DEF_RESET_PC  = 32'hBFC0_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_HOLD = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
        logic        adel;
    } ifid_t;

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge port of the fetch stage.
interface if_stage_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;

    modport master (output inst_req, output inst_addr, input inst_ack, input inst_rdata);
    modport slave  (input inst_req, input inst_addr, output inst_ack, output inst_rdata);
endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load, otherwise a bubble.
module if_stage_if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  stall_i,
    input  logic  flush_i,
    input  logic  load_i,
    input  ifid_t data_i,
    output ifid_t q_o
);

    ifid_t q_q;
    ifid_t q_d;

    // Next IF/ID contents by priority; bubbles keep the old PC fields.
    always_comb begin
        q_d = q_q;
        if (flush_i || (!stall_i && !load_i)) begin
            q_d.instr = NOP_INSTR;
            q_d.valid = 1'b0;
            q_d.adel  = 1'b0;
        end else if (stall_i) begin
            q_d = q_q;
        end else begin
            q_d = data_i;
        end
    end

    // Register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q.instr <= NOP_INSTR;
            q_q.pc    <= 32'd0;
            q_q.pc4   <= 32'd0;
            q_q.valid <= 1'b0;
            q_q.adel  <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM with one-word hold buffer,
// delay-slot-preserving redirects and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallF,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               PCSrcD,
    input  logic [31:0]        PCTargetD,
    if_stage_if.master         imem,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD,
    output logic               AdelD
);

    if_state_e   state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] buf_q, buf_d;
    logic        discard_q, discard_d;
    logic        adv_q, adv_d;

    logic        misaligned_s, req_s, ack_s, drop_s, keep_s, load_s, advance_s;
    logic [31:0] next_pc_s;
    ifid_t       load_data_s, ifid_s;

    assign misaligned_s = pc_misaligned(pcf_q);
    assign req_s        = (state_q == IF_REQ) && !misaligned_s;
    assign ack_s        = req_s && imem.inst_ack;
    assign drop_s       = ack_s && (discard_q || FlushD);
    assign keep_s       = ack_s && !drop_s;
    // A redirect arriving in the same cycle as the advance must already win.
    assign next_pc_s    = PCSrcD ? PCTargetD : (pend_q ? pend_pc_q : pcf_q + 32'd4);

    // State and datapath registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IF_IDLE;
            pcf_q     <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
            buf_q     <= 32'd0;
            discard_q <= 1'b0;
            adv_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcf_q     <= pcf_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            buf_q     <= buf_d;
            discard_q <= discard_d;
            adv_q     <= adv_d;
        end
    end

    // Next-state: FSM transitions, PC advance, pending redirect and hold buffer.
    always_comb begin
        state_d   = state_q;
        pcf_d     = pcf_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        buf_d     = buf_q;
        discard_d = discard_q;
        adv_d     = adv_q;
        advance_s = 1'b0;
        if (PCSrcD) begin
            pend_d    = 1'b1;
            pend_pc_d = PCTargetD;
        end else begin
            pend_d    = pend_q;
        end
        case (state_q)
            IF_IDLE: begin
                // adv_q marks a word delivered under StallF whose PC step was deferred.
                if (PCSrcD && !adv_q) begin
                    pcf_d  = PCTargetD;
                    pend_d = 1'b0;
                end else begin
                    pcf_d  = pcf_q;
                end
                if (!StallF) begin
                    state_d   = IF_REQ;
                    advance_s = adv_q;
                    adv_d     = 1'b0;
                end else begin
                    state_d   = IF_IDLE;
                end
            end
            IF_REQ: begin
                if (misaligned_s) begin
                    advance_s = load_s;
                end else if (ack_s) begin
                    discard_d = 1'b0;
                    if (drop_s || !StallD) begin
                        if (StallF) begin
                            adv_d   = 1'b1;
                            state_d = IF_IDLE;
                        end else begin
                            advance_s = 1'b1;
                        end
                    end else begin
                        buf_d   = imem.inst_rdata;
                        state_d = IF_HOLD;
                    end
                end else if (FlushD) begin
                    discard_d = 1'b1;
                end else begin
                    discard_d = discard_q;
                end
            end
            IF_HOLD: begin
                if (FlushD || !StallD) begin
                    advance_s = 1'b1;
                    state_d   = StallF ? IF_IDLE : IF_REQ;
                end else begin
                    state_d   = IF_HOLD;
                end
            end
            default: state_d = IF_IDLE;
        endcase
        if (advance_s) begin
            pcf_d  = next_pc_s;
            pend_d = 1'b0;
        end else begin
            pend_d = pend_d;
        end
    end

    // Outputs: fetch port and the word offered to the IF/ID register.
    always_comb begin
        load_s            = 1'b0;
        load_data_s.instr = NOP_INSTR;
        load_data_s.pc    = pcf_q;
        load_data_s.pc4   = pcf_q + 32'd4;
        load_data_s.valid = 1'b1;
        load_data_s.adel  = 1'b0;
        case (state_q)
            IF_REQ: begin
                if (misaligned_s) begin
                    load_s           = !StallD && !StallF && !FlushD;
                    load_data_s.adel = 1'b1;
                end else begin
                    load_s            = keep_s && !StallD;
                    load_data_s.instr = imem.inst_rdata;
                end
            end
            IF_HOLD: begin
                load_s            = !StallD && !FlushD;
                load_data_s.instr = buf_q;
            end
            default: load_s = 1'b0;
        endcase
    end

    assign imem.inst_req  = req_s;
    assign imem.inst_addr = pcf_q;

    if_stage_if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .stall_i (StallD),
        .flush_i (FlushD),
        .load_i  (load_s),
        .data_i  (load_data_s),
        .q_o     (ifid_s)
    );

    assign InstrD   = ifid_s.instr;
    assign PCD      = ifid_s.pc;
    assign PCPlus4D = ifid_s.pc4;
    assign ValidD   = ifid_s.valid;
    assign AdelD    = ifid_s.adel;

endmodule

// File: tb/tb_if_stage.sv
// Directed fetch scenarios plus a random-stall stream checked against an
// in-order program model backed by a synthetic instruction memory.
module tb_if_stage;
    import if_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, StallF, StallD, FlushD, PCSrcD;
    logic [31:0] PCTargetD, InstrD, PCD, PCPlus4D;
    logic        ValidD, AdelD;

    if_stage_if bus();

    if_stage #(.RESET_PC(32'hBFC0_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcD(PCSrcD), .PCTargetD(PCTargetD), .imem(bus), .InstrD(InstrD),
        .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .AdelD(AdelD)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          lat   = 1;
    int          cnt   = 0;
    int          n_del = 0;
    bit          rnd_lat = 1'b0;
    bit          mon_on  = 1'b0;
    logic [31:0] exp_del, exp_fetch;
    logic        p_sd, p_fd;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock: edge, stream monitor, then the memory's response for this cycle.
    task automatic cyc();
        p_sd = StallD;
        p_fd = FlushD;
        @(posedge clk);
        #1;
        if (mon_on) begin
            if (bus.inst_req) chk("req_addr", bus.inst_addr, exp_fetch);
            if (!p_sd && !p_fd && ValidD) begin
                chk("stream_pcd", PCD, exp_del);
                chk("stream_instr", InstrD, memf(exp_del));
                chk("stream_pc4", PCPlus4D, exp_del + 32'd4);
                chk("stream_adel", {31'd0, AdelD}, 32'd0);
                exp_del = exp_del + 32'd4;
                n_del++;
            end
        end
        if (bus.inst_req) begin
            if (cnt == 0 && rnd_lat) lat = int'($urandom_range(1, 4));
            if (cnt >= lat) begin
                bus.inst_ack   = 1'b1;
                bus.inst_rdata = memf(bus.inst_addr);
                cnt = 0;
                if (mon_on) exp_fetch = exp_fetch + 32'd4;
            end else begin
                bus.inst_ack   = 1'b0;
                bus.inst_rdata = 32'd0;
                cnt++;
            end
        end else begin
            bus.inst_ack   = 1'b0;
            bus.inst_rdata = 32'd0;
            cnt = 0;
        end
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!bus.inst_ack && n < budget) begin
            cyc();
            n++;
        end
        chk("ack_timeout", {31'd0, bus.inst_ack}, 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_instr"}, InstrD, 32'd0);
        chk({tag, "_pcd"}, PCD, 32'd0);
        chk({tag, "_pc4"}, PCPlus4D, 32'd0);
        chk({tag, "_valid"}, {31'd0, ValidD}, 32'd0);
        chk({tag, "_adel"}, {31'd0, AdelD}, 32'd0);
        chk({tag, "_req"}, {31'd0, bus.inst_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcD = 1'b0;
        PCTargetD = 32'd0; bus.inst_ack = 1'b0; bus.inst_rdata = 32'd0;

        // 1: reset, then back-to-back fetches at 1-cycle latency
        cyc(); cyc();
        chk_reset_outputs("rst");
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 3; i++) begin
            wait_ack(10);
            chk("seq_addr", bus.inst_addr, 32'hBFC0_0000 + 32'(4 * i));
            cyc();
            chk("seq_valid", {31'd0, ValidD}, 32'd1);
            chk("seq_pcd", PCD, 32'hBFC0_0000 + 32'(4 * i));
            chk("seq_instr", InstrD, memf(32'hBFC0_0000 + 32'(4 * i)));
            chk("seq_pc4", PCPlus4D, 32'hBFC0_0004 + 32'(4 * i));
        end

        // 2: latency 3, StallD for 2 cycles on the ack -> hold buffer
        lat = 3;
        wait_ack(10);
        chk("hold_addr", bus.inst_addr, 32'hBFC0_000C);
        StallD = 1'b1;
        cyc();
        chk("hold_req0", {31'd0, bus.inst_req}, 32'd0);
        chk("hold_pcd_kept", PCD, 32'hBFC0_0008);
        cyc();
        chk("hold_req1", {31'd0, bus.inst_req}, 32'd0);
        StallD = 1'b0;
        cyc();
        chk("hold_rel_pcd", PCD, 32'hBFC0_000C);
        chk("hold_rel_instr", InstrD, memf(32'hBFC0_000C));
        chk("hold_rel_valid", {31'd0, ValidD}, 32'd1);
        chk("hold_next_addr", bus.inst_addr, 32'hBFC0_0010);

        // 3: branch at BFC00010 resolves while BFC00014 is in flight
        lat = 1;
        wait_ack(10);
        cyc();
        chk("br_pcd", PCD, 32'hBFC0_0010);
        PCSrcD = 1'b1; PCTargetD = 32'hBFC0_0100;
        cyc();
        PCSrcD = 1'b0;
        chk("br_slot_addr", bus.inst_addr, 32'hBFC0_0014);
        wait_ack(10);
        cyc();
        chk("br_slot_pcd", PCD, 32'hBFC0_0014);
        chk("br_slot_instr", InstrD, memf(32'hBFC0_0014));
        chk("br_target_addr", bus.inst_addr, 32'hBFC0_0100);

        // 4: flush + redirect with a fetch outstanding; its late ack is dropped
        lat = 3;
        FlushD = 1'b1; PCSrcD = 1'b1; PCTargetD = 32'hBFC0_0380;
        cyc();
        FlushD = 1'b0; PCSrcD = 1'b0;
        chk("fl_valid", {31'd0, ValidD}, 32'd0);
        chk("fl_instr", InstrD, 32'd0);
        chk("fl_inflight_addr", bus.inst_addr, 32'hBFC0_0100);
        wait_ack(10);
        cyc();
        chk("fl_drop_valid", {31'd0, ValidD}, 32'd0);
        chk("fl_new_addr", bus.inst_addr, 32'hBFC0_0380);

        // 5: misaligned redirect target -> no request, address-error bubble
        PCSrcD = 1'b1; PCTargetD = 32'h0000_1002;
        cyc();
        PCSrcD = 1'b0;
        wait_ack(10);
        cyc();
        chk("mis_slot_pcd", PCD, 32'hBFC0_0380);
        chk("mis_noreq", {31'd0, bus.inst_req}, 32'd0);
        cyc();
        chk("mis_adel", {31'd0, AdelD}, 32'd1);
        chk("mis_pcd", PCD, 32'h0000_1002);
        chk("mis_instr", InstrD, 32'd0);
        chk("mis_valid", {31'd0, ValidD}, 32'd1);
        chk("mis_noreq2", {31'd0, bus.inst_req}, 32'd0);

        // Random stalls and latencies: stream must be in order, no loss or duplication
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        exp_del = 32'hBFC0_0000; exp_fetch = 32'hBFC0_0000;
        rnd_lat = 1'b1; mon_on = 1'b1;
        for (int i = 0; i < 600; i++) begin
            StallD = ($urandom_range(0, 3) == 0);
            StallF = ($urandom_range(0, 6) == 0);
            cyc();
        end
        StallD = 1'b0; StallF = 1'b0;
        cyc(); cyc();
        for (int i = 0; i < 10 && bus.inst_ack; i++) cyc();
        chk("rand_drained", exp_del, exp_fetch);
        chk("rand_progress", {31'd0, (n_del > 40)}, 32'd1);
        mon_on = 1'b0; rnd_lat = 1'b0;

        // 6: reset mid-request as the ack arrives; a stray ack after reset is ignored
        lat = 2;
        wait_ack(10);
        rst = 1'b0;
        cyc();
        chk_reset_outputs("midrst");
        rst = 1'b1;
        bus.inst_ack = 1'b1; bus.inst_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("stray_valid", {31'd0, ValidD}, 32'd0);
        chk("stray_instr", InstrD, 32'd0);
        chk("refetch_addr", bus.inst_addr, 32'hBFC0_0000);
        wait_ack(10);
        cyc();
        chk("refetch_pcd", PCD, 32'hBFC0_0000);
        chk("refetch_instr", InstrD, memf(32'hBFC0_0000));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
